// File: rtl/tally_pkg.sv
// rtl/tally_pkg.sv - shared parameter defaults and divide-control state encoding for tally
package tally_pkg;

  localparam int SCORE_W_DEF = 4;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } div_state_t;

endpackage

// File: rtl/tally_divider.sv
// rtl/tally_divider.sv - unsigned restoring shift-subtract divider, one quotient bit per cycle
module tally_divider #(
  parameter int SUM_W = 12,
  parameter int Q_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);

  localparam int                STEP_W = $clog2(SUM_W + 1);
  localparam logic [STEP_W-1:0] STEPS  = STEP_W'(SUM_W);

  logic [SUM_W-1:0]  r_rem;
  logic [SUM_W-1:0]  r_quo;
  logic [SUM_W-1:0]  r_div;
  logic [STEP_W-1:0] r_steps;
  logic              r_busy;

  logic [SUM_W:0]    w_shift;
  logic [SUM_W:0]    w_trial;

  // Partial remainder shifted left with the next dividend bit; the trial
  // difference borrows (top bit set) exactly when the shifted remainder is
  // smaller than the divisor, since the remainder is always below the divisor.
  assign w_shift  = {r_rem, r_quo[SUM_W-1]};
  assign w_trial  = w_shift - {1'b0, r_div};
  assign quotient = r_quo[Q_W-1:0];
  assign done     = r_busy && (r_steps == '0);

  // Load operands on start, then run SUM_W steps; done is held for one cycle after the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_steps <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_steps <= STEPS;
      r_rem   <= '0;
      r_quo   <= dividend;
      r_div   <= divisor;
    end else if (r_busy) begin
      if (r_steps == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_steps <= r_steps - STEP_W'(1);
        if (w_trial[SUM_W]) begin
          r_rem <= w_shift[SUM_W-1:0];
          r_quo <= {r_quo[SUM_W-2:0], 1'b0};
        end else begin
          r_rem <= w_trial[SUM_W-1:0];
          r_quo <= {r_quo[SUM_W-2:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/tally.sv
// rtl/tally.sv - running-average scorer: accumulates strobed scores and divides sum by count
module tally #(
  parameter int SCORE_W = tally_pkg::SCORE_W_DEF,
  parameter int COUNT_W = tally_pkg::COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               score_ready,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] score_avg
);

  import tally_pkg::*;

  localparam int                 SUM_W     = SCORE_W + COUNT_W;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [SUM_W-1:0]   r_sum;
  logic [COUNT_W-1:0] r_count;
  logic               r_pending;
  div_state_t         r_state;
  logic [SCORE_W-1:0] r_avg;

  logic               w_accept;
  logic               w_start;
  logic               w_done;
  logic [SCORE_W-1:0] w_quotient;

  // A full counter freezes sum and count, so the worst-case sum always fits SUM_W bits
  assign w_accept  = score_ready && (r_count != COUNT_MAX);
  assign w_start   = (r_state == ST_IDLE) && r_pending;
  assign score_avg = r_avg;

  // Accumulate accepted samples into the running sum and sample count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sum   <= r_sum + SUM_W'(score);
      r_count <= r_count + COUNT_W'(1);
    end
  end

  // Pending marks new data; a same-cycle strobe beats the clear so that sample gets its own division
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end
  end

  // Divide-control FSM; the output register is written only when a division completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_avg   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (w_done) begin
            r_avg   <= w_quotient;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tally_divider #(
    .SUM_W (SUM_W),
    .Q_W   (SCORE_W)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .dividend (r_sum),
    .divisor  (SUM_W'(r_count)),
    .quotient (w_quotient),
    .done     (w_done)
  );

endmodule

// File: tb/tb_tally.sv
// tb/tb_tally.sv - self-checking bench for tally against a sum/count reference model
module tb_tally;

  localparam int SCORE_W = 4;
  localparam int COUNT_W = 8;
  localparam int SUM_W   = SCORE_W + COUNT_W;
  localparam int LAT     = SUM_W + 2;
  localparam int SETTLE  = 2 * LAT + 4;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic               clk;
  logic               reset;
  logic               score_ready;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] score_avg;

  int n_compared;
  int n_mismatched;
  int m_sum;
  int m_count;

  tally #(
    .SCORE_W (SCORE_W),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .score_ready (score_ready),
    .score       (score),
    .score_avg   (score_avg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_avg();
    if (m_count == 0) return 0;
    return m_sum / m_count;
  endfunction

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    score_ready = 1'b0;
    score       = '0;
    @(negedge clk);
    reset   = 1'b0;
    m_sum   = 0;
    m_count = 0;
  endtask

  task automatic strobe(input logic [SCORE_W-1:0] s);
    score_ready = 1'b1;
    score       = s;
    if (m_count < CMAX) begin
      m_sum   += int'(s);
      m_count += 1;
    end
    @(negedge clk);
    score_ready = 1'b0;
    score       = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_compared++;
    if (score_avg !== 4'd0) begin
      n_mismatched++;
      $display("FAIL reset_avg: got %0d want 0", score_avg);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      n_compared++;
      if (score_avg !== 4'd0) begin
        n_mismatched++;
        $display("FAIL idle_avg cycle %0d: got %0d want 0", i, score_avg);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    strobe(4'd10);
    n_compared++;
    if (score_avg !== 4'd0) begin
      n_mismatched++;
      $display("FAIL lat_pre: got %0d want 0", score_avg);
    end
    tick(5);
    strobe(4'd7);
    tick(LAT - 7);
    n_compared++;
    if (score_avg !== 4'd0) begin
      n_mismatched++;
      $display("FAIL lat_early: got %0d want 0", score_avg);
    end
    tick(1);
    n_compared++;
    if (score_avg !== 4'd10) begin
      n_mismatched++;
      $display("FAIL lat_first: got %0d want 10", score_avg);
    end
    tick(LAT - 1);
    n_compared++;
    if (score_avg !== 4'd10) begin
      n_mismatched++;
      $display("FAIL lat_hold: got %0d want 10", score_avg);
    end
    tick(1);
    n_compared++;
    if (score_avg !== 4'd8) begin
      n_mismatched++;
      $display("FAIL lat_second: got %0d want 8", score_avg);
    end
  endtask

  task automatic test_steps();
    logic [SCORE_W-1:0] scores [4];
    logic [SCORE_W-1:0] expect_avg [4];
    scores     = '{4'd3, 4'd4, 4'd4, 4'd15};
    expect_avg = '{4'd3, 4'd3, 4'd3, 4'd6};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(scores[i]);
      tick(19);
      n_compared++;
      if (score_avg !== expect_avg[i]) begin
        n_mismatched++;
        $display("FAIL steps[%0d]: got %0d want %0d", i, score_avg, expect_avg[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX; i++) strobe(4'd15);
    for (int i = 0; i < 10; i++) strobe(4'd0);
    tick(SETTLE);
    for (int i = 0; i < 10; i++) begin
      n_compared++;
      if (score_avg !== 4'd15) begin
        n_mismatched++;
        $display("FAIL sat_avg cycle %0d: got %0d want 15", i, score_avg);
      end
      tick(1);
    end
    // Last accepted sample differs from the rest, then later strobes must be ignored
    do_reset();
    for (int i = 0; i < CMAX - 1; i++) strobe(4'd15);
    strobe(4'd0);
    for (int i = 0; i < 5; i++) strobe(4'd15);
    tick(SETTLE);
    n_compared++;
    if (score_avg !== SCORE_W'(model_avg())) begin
      n_mismatched++;
      $display("FAIL sat_edge: got %0d want %0d", score_avg, model_avg());
    end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    strobe(4'd12);
    tick(LAT + 2);
    n_compared++;
    if (score_avg !== 4'd12) begin
      n_mismatched++;
      $display("FAIL rmd_setup: got %0d want 12", score_avg);
    end
    strobe(4'd4);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset   = 1'b0;
    m_sum   = 0;
    m_count = 0;
    n_compared++;
    if (score_avg !== 4'd0) begin
      n_mismatched++;
      $display("FAIL rmd_cleared: got %0d want 0", score_avg);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_compared++;
      if (score_avg !== 4'd0) begin
        n_mismatched++;
        $display("FAIL rmd_no_stale cycle %0d: got %0d want 0", i, score_avg);
      end
    end
    strobe(4'd5);
    tick(LAT - 1);
    n_compared++;
    if (score_avg !== 4'd0) begin
      n_mismatched++;
      $display("FAIL rmd_pre: got %0d want 0", score_avg);
    end
    tick(1);
    n_compared++;
    if (score_avg !== 4'd5) begin
      n_mismatched++;
      $display("FAIL rmd_after: got %0d want 5", score_avg);
    end
  endtask

  task automatic test_back_to_back();
    int  allowed[$];
    bit  found;
    do_reset();
    allowed.push_back(0);
    for (int i = 0; i < 40; i++) begin
      strobe(SCORE_W'($urandom_range(0, 15)));
      allowed.push_back(model_avg());
      found = 1'b0;
      foreach (allowed[k]) if (int'(score_avg) == allowed[k]) found = 1'b1;
      n_compared++;
      if (!found) begin
        n_mismatched++;
        $display("FAIL b2b_prefix cycle %0d: got %0d, not the mean of any sample prefix", i, score_avg);
      end
    end
    tick(SETTLE);
    n_compared++;
    if (score_avg !== SCORE_W'(model_avg())) begin
      n_mismatched++;
      $display("FAIL b2b_final: got %0d want %0d", score_avg, model_avg());
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        strobe(SCORE_W'($urandom_range(0, 15)));
        if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 20));
      end
      tick(SETTLE);
      n_compared++;
      if (score_avg !== SCORE_W'(model_avg())) begin
        n_mismatched++;
        $display("FAIL rand_avg round %0d: got %0d want %0d (sum %0d count %0d)",
                 r, score_avg, model_avg(), m_sum, m_count);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_sum        = 0;
    m_count      = 0;
    reset        = 1'b1;
    score_ready  = 1'b0;
    score        = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_steps();
    test_saturation();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
